// File: rtl/des_key_schedule_pkg.sv
// des_pkg: DES key-schedule tables, state encoding and C/D rotate helpers.
// Table entries are FIPS 46-3 bit numbers (1-based); vector index = bit - 1.
package des_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [27:0] half_t;
  localparam int PC1_TABLE [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };
  localparam int SHIFT_SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  // DES left rotate moves bit i+1 into bit i, i.e. a vector right shift
  function automatic half_t rot_left(input half_t h, input logic two);
    return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
  endfunction
  function automatic half_t rot_right(input half_t h, input logic two);
    return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction
endpackage

// File: rtl/des_key_schedule_if.sv
// des_key_schedule_if: key-load, schedule-request and round-key handshake bundle.
interface des_key_schedule_if #(
  parameter int NUM_KEYS = 3
);
  localparam int SEL_W = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;
  logic                  key_load;
  logic [64*NUM_KEYS-1:0] key_in;
  logic                  start;
  logic [SEL_W-1:0]      key_sel;
  logic                  decrypt;
  logic                  key_ready;
  logic [47:0]           round_key;
  logic [3:0]            round_num;
  logic                  key_valid;
  logic                  busy;
  logic                  done;
  modport master (
    output key_load, key_in, start, key_sel, decrypt, key_ready,
    input  round_key, round_num, key_valid, busy, done
  );
  modport slave (
    input  key_load, key_in, start, key_sel, decrypt, key_ready,
    output round_key, round_num, key_valid, busy, done
  );
endinterface

// File: rtl/des_key_schedule_perm.sv
// key_permutation1/key_permutation2: combinational DES PC-1 (64->56) and PC-2 (56->48).
module key_permutation1
  import des_pkg::*;
(
  input  logic [63:0] key_i,
  output logic [55:0] pc1_o
);
  logic unused_parity;
  assign unused_parity = ^key_i;
  for (genvar j = 0; j < 56; j++) begin : g_pc1
    assign pc1_o[j] = key_i[PC1_TABLE[j] - 1];
  end
endmodule

module key_permutation2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] rk_o
);
  logic unused_cd;
  assign unused_cd = ^cd_i;
  for (genvar j = 0; j < 48; j++) begin : g_pc2
    assign rk_o[j] = cd_i[PC2_TABLE[j] - 1];
  end
endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: stores NUM_KEYS DES keys and emits the 16 round keys of one, in
// encrypt or decrypt order, one per valid/ready handshake.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_KEYS = 3
) (
  input  logic                clk,
  input  logic                n_rst,
  des_key_schedule_if.slave   bus
);
  state_t                 state_q;
  logic [64*NUM_KEYS-1:0] store_q;
  half_t                  c_q, d_q, c_ld_d, d_ld_d, c_rot_d, d_rot_d;
  logic                   dec_q, key_valid_q, busy_q, done_q, two;
  logic [3:0]             round_num_q, sched_idx;
  logic [63:0]            sel_key;
  logic [55:0]            pc1;
  // out-of-range selects fall back to key 0
  always_comb begin
    sel_key = store_q[63:0];
    for (int k = 1; k < NUM_KEYS; k++)
      sel_key = (32'(bus.key_sel) == k) ? store_q[64*k +: 64] : sel_key;
  end
  key_permutation1 u_pc1 (.key_i(sel_key), .pc1_o(pc1));
  // encrypt pre-applies the first shift so K1 is ready on the first valid cycle
  assign c_ld_d = bus.decrypt ? pc1[27:0]  : rot_left(pc1[27:0], 1'b0);
  assign d_ld_d = bus.decrypt ? pc1[55:28] : rot_left(pc1[55:28], 1'b0);
  assign sched_idx = dec_q ? 4'd15 - round_num_q : round_num_q + 4'd1;
  assign two = SHIFT_SCHED[sched_idx] == 2;
  assign c_rot_d = dec_q ? rot_right(c_q, two) : rot_left(c_q, two);
  assign d_rot_d = dec_q ? rot_right(d_q, two) : rot_left(d_q, two);
  key_permutation2 u_pc2 (.cd_i({d_q, c_q}), .rk_o(bus.round_key));
  assign bus.round_num = round_num_q;
  assign bus.key_valid = key_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      store_q     <= '0;
      c_q         <= '0;
      d_q         <= '0;
      dec_q       <= 1'b0;
      round_num_q <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (bus.key_load) store_q <= bus.key_in;
      case (state_q)
        IDLE: if (bus.start) begin
          c_q         <= c_ld_d;
          d_q         <= d_ld_d;
          dec_q       <= bus.decrypt;
          round_num_q <= '0;
          key_valid_q <= 1'b1;
          busy_q      <= 1'b1;
          state_q     <= RUN;
        end
        RUN: if (bus.key_ready) begin
          if (round_num_q == 4'd15) begin
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            round_num_q <= round_num_q + 4'd1;
            c_q         <= c_rot_d;
            d_q         <= d_rot_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
